// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt-acknowledge sequencer and OCW2 decode.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        WAIT2,
        ACK2
    } seq_state_e;

    // {R, SL, EOI} field of OCW2
    typedef enum logic [2:0] {
        OCW2_AEOI_ROT_CLR = 3'b000,
        OCW2_NS_EOI       = 3'b001,
        OCW2_NOP          = 3'b010,
        OCW2_SP_EOI       = 3'b011,
        OCW2_AEOI_ROT_SET = 3'b100,
        OCW2_ROT_NS_EOI   = 3'b101,
        OCW2_SET_PRIO     = 3'b110,
        OCW2_ROT_SP_EOI   = 3'b111
    } ocw2_cmd_e;

    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] index_to_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/ocw2_eoi_decoder.sv
// Combinational decode of an OCW2 byte into EOI clear mask, rotation update and AEOI-rotate mode.
module ocw2_eoi_decoder
    import pic_pkg::*;
(
    input  logic [7:0] ocw2_data,
    input  logic [7:0] highest_in_service,
    output logic [7:0] eoi_mask,
    output logic       rotate_valid,
    output logic [2:0] rotate_value,
    output logic       aeoi_mode_set,
    output logic       aeoi_mode_clr
);

    ocw2_cmd_e  cmd;
    logic [2:0] level;

    always_comb begin
        cmd           = ocw2_cmd_e'(ocw2_data[7:5]);
        level         = ocw2_data[2:0];
        eoi_mask      = '0;
        rotate_valid  = 1'b0;
        rotate_value  = '0;
        aeoi_mode_set = 1'b0;
        aeoi_mode_clr = 1'b0;
        case (cmd)
            OCW2_NS_EOI: begin
                eoi_mask = highest_in_service;
            end
            OCW2_SP_EOI: begin
                eoi_mask = index_to_onehot(level);
            end
            OCW2_ROT_NS_EOI: begin
                // nothing in service means nothing to clear and no new lowest level
                if (highest_in_service != '0) begin
                    eoi_mask     = highest_in_service;
                    rotate_valid = 1'b1;
                    rotate_value = onehot_to_index(highest_in_service);
                end
            end
            OCW2_ROT_SP_EOI: begin
                eoi_mask     = index_to_onehot(level);
                rotate_valid = 1'b1;
                rotate_value = level;
            end
            OCW2_SET_PRIO: begin
                rotate_valid = 1'b1;
                rotate_value = level;
            end
            OCW2_AEOI_ROT_SET: aeoi_mode_set = 1'b1;
            OCW2_AEOI_ROT_CLR: aeoi_mode_clr = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode INTA handshake sequencer: drives INT, ISR set/EOI strobes, priority rotation and the vector byte.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned SPURIOUS_LEVEL = 7,
    parameter bit          AEOI_ROTATE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inta_n,
    input  logic [7:0] interrupt_request,
    input  logic [7:0] highest_in_service,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
    output logic       int_out,
    output logic       in_service_set,
    output logic [7:0] in_service_level,
    output logic [7:0] end_of_interrupt,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    seq_state_e state_q, state_d;
    logic       inta_n_q;
    logic [7:0] latched_level_q, latched_level_d;
    logic       spurious_q, spurious_d;
    logic       rotate_in_aeoi_q, rotate_in_aeoi_d;
    logic       int_out_q, int_out_d;
    logic       set_q, set_d;
    logic [7:0] level_q, level_d;
    logic [7:0] eoi_q, eoi_d;
    logic [2:0] rotate_q, rotate_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_en_q, data_en_d;

    logic       fall, rise;
    logic [7:0] aeoi_mask;
    logic       aeoi_rotate;

    logic [7:0] dec_eoi_mask;
    logic       dec_rotate_valid;
    logic [2:0] dec_rotate_value;
    logic       dec_aeoi_set, dec_aeoi_clr;

    ocw2_eoi_decoder u_ocw2_dec (
        .ocw2_data          (ocw2_data),
        .highest_in_service (highest_in_service),
        .eoi_mask           (dec_eoi_mask),
        .rotate_valid       (dec_rotate_valid),
        .rotate_value       (dec_rotate_value),
        .aeoi_mode_set      (dec_aeoi_set),
        .aeoi_mode_clr      (dec_aeoi_clr)
    );

    assign fall = inta_n_q & ~inta_n;
    assign rise = ~inta_n_q & inta_n;

    always_comb begin
        state_d         = state_q;
        latched_level_d = latched_level_q;
        spurious_d      = spurious_q;
        set_d           = 1'b0;
        level_d         = '0;
        data_out_d      = data_out_q;
        aeoi_mask       = '0;
        aeoi_rotate     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = ACK1;
                    if (interrupt_request != '0) begin
                        latched_level_d = interrupt_request;
                        spurious_d      = 1'b0;
                        set_d           = 1'b1;
                        level_d         = interrupt_request;
                    end else begin
                        latched_level_d = index_to_onehot(3'(SPURIOUS_LEVEL));
                        spurious_d      = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (rise) state_d = WAIT2;
            end
            WAIT2: begin
                if (fall) begin
                    state_d    = ACK2;
                    data_out_d = {vector_base, onehot_to_index(latched_level_q)};
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d    = IDLE;
                    data_out_d = '0;
                    if (auto_eoi && !spurious_q) begin
                        aeoi_mask   = latched_level_q;
                        aeoi_rotate = rotate_in_aeoi_q && AEOI_ROTATE_EN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        data_en_d = (state_d == ACK2);
        int_out_d = (state_d == IDLE) && (interrupt_request != '0);

        // AEOI and OCW2 EOI merge; an OCW2 rotation overrides the AEOI one
        eoi_d = aeoi_mask | (ocw2_write ? dec_eoi_mask : 8'h00);

        rotate_d = rotate_q;
        if (ocw2_write && dec_rotate_valid) begin
            rotate_d = dec_rotate_value;
        end else if (aeoi_rotate) begin
            rotate_d = onehot_to_index(latched_level_q);
        end

        rotate_in_aeoi_d = rotate_in_aeoi_q;
        if (ocw2_write && dec_aeoi_set) begin
            rotate_in_aeoi_d = 1'b1;
        end else if (ocw2_write && dec_aeoi_clr) begin
            rotate_in_aeoi_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            inta_n_q         <= 1'b1;
            latched_level_q  <= '0;
            spurious_q       <= 1'b0;
            rotate_in_aeoi_q <= 1'b0;
            int_out_q        <= 1'b0;
            set_q            <= 1'b0;
            level_q          <= '0;
            eoi_q            <= '0;
            rotate_q         <= 3'b111;
            data_out_q       <= '0;
            data_en_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            inta_n_q         <= inta_n;
            latched_level_q  <= latched_level_d;
            spurious_q       <= spurious_d;
            rotate_in_aeoi_q <= rotate_in_aeoi_d;
            int_out_q        <= int_out_d;
            set_q            <= set_d;
            level_q          <= level_d;
            eoi_q            <= eoi_d;
            rotate_q         <= rotate_d;
            data_out_q       <= data_out_d;
            data_en_q        <= data_en_d;
        end
    end

    assign int_out          = int_out_q;
    assign in_service_set   = set_q;
    assign in_service_level = level_q;
    assign end_of_interrupt = eoi_q;
    assign priority_rotate  = rotate_q;
    assign data_out         = data_out_q;
    assign data_out_en      = data_en_q;

endmodule
